integrator: RTL and testbench
=============================

// Module: integrator
// PURPOSE
//   Digital integral (I-only) feedback controller for the ADC->DAC feedback loop.
//   - On each valid ADC sample, computes error = adc_data - setpoint.
//   - Accumulates the error into a saturating signed integrator.
//   - Drives the scaled, saturated integral onto dac_data.
//   - Sits between the ADC sample stream and the DAC word; integrate gates accumulation.
// PARAMETERS
//   ADC_WIDTH  19  width of adc_data/setpoint, signed two's complement
//   DAC_WIDTH  17  width of dac_data, signed two's complement
//   ACC_WIDTH  32  accumulator width, signed; must be > ADC_WIDTH+1 and >= DAC_WIDTH+GAIN_SHIFT
//   GAIN_SHIFT 0   integral gain = 2^-GAIN_SHIFT (arithmetic right shift of accumulator)
// PORTS
//   clk        in   1          single system clock, all logic rising-edge
//   rst        in   1          asynchronous, active-high reset
//   adc_valid  in   1          single-cycle strobe; adc_data valid this cycle
//   integrate  in   1          1: accumulate samples; 0: hold integrator (freeze)
//   adc_data   in   ADC_WIDTH  signed ADC sample
//   setpoint   in   ADC_WIDTH  signed target; sampled together with adc_data
//   dac_data   out  DAC_WIDTH  signed, registered integral output
// BEHAVIOUR
//   Reset (async, rst=1): err, err_valid, accumulator, dac_data all <= 0.
//   Stage 1 (adc_valid=1):
//     - err <= sign-extended adc_data - setpoint, ADC_WIDTH+1 bits, no overflow possible.
//     - err_valid <= adc_valid & integrate; integrate is sampled in the same cycle as adc_valid.
//   Stage 2 (err_valid=1):
//     - acc <= sat_ACC(acc + sext(err)).
//     - Sum is computed at ACC_WIDTH+1 bits, then clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
//   Stage 3, every cycle:
//     - dac_data <= sat_DAC(acc >>> GAIN_SHIFT).
//     - Clamped to [-2^(DAC_WIDTH-1), 2^(DAC_WIDTH-1)-1]; default range -65536..65535.
//   Latency: dac_data reflects a sample 3 clk edges after the adc_valid edge.
//   adc_valid=0: no accumulator change; dac_data holds its value.
//   integrate=0: valid samples are discarded and the accumulator holds; it is never cleared.
//   integrate 0->1: resumes from the held value, with no jump.
//   adc_valid on consecutive cycles: every sample is accumulated (full throughput, 1/clk).
//   setpoint may change at any time; it takes effect on the next adc_valid.
//   Reset mid-operation clears the whole pipeline immediately; no output glitch beyond going to 0.
// STRUCTURE
//   Shared package: ADC_WIDTH/DAC_WIDTH defaults; a signed saturate function (in width -> out width).
//   One sub-module is natural: sat_add (signed add + clamp, parameterised width), used in stage 2.
//   Output clamp uses the package saturate function; the rest is flat in integrator.
// TESTING  (defaults, setpoint=1000, adc_valid 1-cycle pulses ~16 clk apart)
//   1. Reset: dac_data=0; no valid -> stays 0.
//   2. integrate=1, samples 1100,1500,2800,10000 -> dac_data 100,600,2400,11400, each 3 clk after its strobe.
//   3. integrate=0, samples 10000,1100 -> dac_data holds 11400.
//   4. integrate=1, samples 10000,1500,2800 -> dac_data 20400,20900,22700.
//   5. setpoint=0, adc_data=+262143 repeated -> dac_data clamps at 65535 and stays.
//      adc_data=-262144 repeated -> walks down, clamps at -65536.
//   6. Back-to-back adc_valid for 4 cycles, each with error 10 -> +40 total.
//      Assert rst mid-stream -> all zero asynchronously.

Source files
------------

// File: rtl/integrator_pkg.sv
// Shared widths and signed saturation helper for the integral controller.
// Provides default port widths and sat_s(): clamp a 64-bit signed value to w bits.
package integrator_pkg;

   localparam int ADC_WIDTH_DEF = 19;
   localparam int DAC_WIDTH_DEF = 17;

   // Clamp x into [-2^(w-1), 2^(w-1)-1]; caller keeps the low w bits.
   function automatic logic signed [63:0] sat_s(
      input logic signed [63:0] x,
      input int                 w
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi)
         sat_s = hi;
      else if (x < lo)
         sat_s = lo;
      else
         sat_s = x;
   endfunction

endpackage

// File: rtl/integrator_sat_add.sv
// Signed adder with clamp to the W-bit two's complement range.
// Ports: a, b (W-bit signed operands), y (W-bit signed saturated sum).
module integrator_sat_add #(
   parameter int W = 32
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] y
);

   logic [W:0] sum;

   assign sum = {a[W-1], a} + {b[W-1], b};

   // Top two bits disagree only on overflow; sum[W] is the true sign.
   always_comb begin
      y = sum[W-1:0];
      if (sum[W] != sum[W-1])
         y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   end

endmodule

// File: rtl/integrator.sv
// I-only feedback controller: error = adc - setpoint, saturating accumulate, scaled DAC word.
// Ports: clk, rst (async high), adc_valid, integrate, adc_data, setpoint, dac_data (registered).
module integrator
   import integrator_pkg::*;
#(
   parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
   parameter int DAC_WIDTH  = DAC_WIDTH_DEF,
   parameter int ACC_WIDTH  = 32,
   parameter int GAIN_SHIFT = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        adc_valid,
   input  logic                        integrate,
   input  logic signed [ADC_WIDTH-1:0] adc_data,
   input  logic signed [ADC_WIDTH-1:0] setpoint,
   output logic signed [DAC_WIDTH-1:0] dac_data
);

   logic signed [ADC_WIDTH:0]   err;
   logic                        err_valid;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] err_ext;
   logic signed [ACC_WIDTH-1:0] acc_sum;
   logic signed [63:0]          acc_sh;

   // Stage 1: one extra bit makes the difference exact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err       <= '0;
         err_valid <= 1'b0;
      end else begin
         err_valid <= adc_valid & integrate;
         if (adc_valid)
            err <= {adc_data[ADC_WIDTH-1], adc_data}
                 - {setpoint[ADC_WIDTH-1], setpoint};
      end
   end

   assign err_ext = {{(ACC_WIDTH-ADC_WIDTH-1){err[ADC_WIDTH]}}, err};

   integrator_sat_add #(.W(ACC_WIDTH)) u_sat_add (
      .a (acc),
      .b (err_ext),
      .y (acc_sum)
   );

   // Stage 2: accumulator only moves on gated samples, so it holds otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (err_valid)
         acc <= acc_sum;
   end

   assign acc_sh = 64'(acc >>> GAIN_SHIFT);

   // Stage 3: refreshed every cycle from the held accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dac_data <= '0;
      else
         dac_data <= DAC_WIDTH'(sat_s(acc_sh, DAC_WIDTH));
   end

endmodule

// File: tb/tb_integrator.sv
// Directed bench for integrator: vector table with latency checks plus saturation/reset sequences.
// Drives inputs 1 time unit after rising edges and samples 1 unit after rising edges.
module tb_integrator;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               adc_valid = 1'b0;
   logic               integrate = 1'b0;
   logic signed [18:0] adc_data = '0;
   logic signed [18:0] setpoint = '0;
   logic signed [16:0] dac_data;

   int errors = 0;
   int checks = 0;

   integrator dut (
      .clk       (clk),
      .rst       (rst),
      .adc_valid (adc_valid),
      .integrate (integrate),
      .adc_data  (adc_data),
      .setpoint  (setpoint),
      .dac_data  (dac_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic integ;
      int   sp;
      int   adc;
      int   exp_dac;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input int exp);
      checks++;
      if (dac_data != exp) begin
         errors++;
         $display("FAIL %s: dac_data=%0d expected=%0d", name, dac_data, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Back-to-back strobes with constant inputs, then drain the pipeline.
   task automatic burst(input int n, input int sp, input int adc);
      setpoint  = 19'(sp);
      adc_data  = 19'(adc);
      integrate = 1'b1;
      adc_valid = 1'b1;
      repeat (n) step();
      adc_valid = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      int prev;

      vecs[0]  = '{1'b1, 1000, 1100, 100};
      vecs[1]  = '{1'b1, 1000, 1500, 600};
      vecs[2]  = '{1'b1, 1000, 2800, 2400};
      vecs[3]  = '{1'b1, 1000, 10000, 11400};
      vecs[4]  = '{1'b0, 1000, 10000, 11400};
      vecs[5]  = '{1'b0, 1000, 1100, 11400};
      vecs[6]  = '{1'b1, 1000, 10000, 20400};
      vecs[7]  = '{1'b1, 1000, 1500, 20900};
      vecs[8]  = '{1'b1, 1000, 2800, 22700};
      vecs[9]  = '{1'b1, 0, 262143, 65535};
      vecs[10] = '{1'b1, 0, 262143, 65535};
      vecs[11] = '{1'b1, 0, -262144, 65535};
      vecs[12] = '{1'b1, 0, -262144, 22698};
      vecs[13] = '{1'b1, 0, -262144, -65536};
      vecs[14] = '{1'b1, 0, -262144, -65536};

      // Reset state
      #2;
      check("reset_async", 0);
      step();
      step();
      rst = 1'b0;
      repeat (10) step();
      check("idle_after_reset", 0);

      prev = 0;
      foreach (vecs[i]) begin
         integrate = vecs[i].integ;
         setpoint  = 19'(vecs[i].sp);
         adc_data  = 19'(vecs[i].adc);
         adc_valid = 1'b1;
         step();
         adc_valid = 1'b0;
         adc_data  = '0;
         step();
         check($sformatf("vec%0d_latency_hold", i), prev);
         step();
         check($sformatf("vec%0d_result", i), vecs[i].exp_dac);
         repeat (13) step();
         check($sformatf("vec%0d_idle_hold", i), vecs[i].exp_dac);
         prev = vecs[i].exp_dac;
      end

      // Back-to-back samples, error 10 each
      rst = 1'b1;
      #1;
      rst = 1'b0;
      step();
      check("reset_before_burst", 0);
      burst(4, 1000, 1010);
      check("burst4_sum", 40);

      // Reset with samples in flight
      setpoint  = 19'(1000);
      adc_data  = 19'(2000);
      adc_valid = 1'b1;
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      check("reset_mid_stream", 0);
      adc_valid = 1'b0;
      step();
      rst = 1'b0;
      repeat (5) step();
      check("after_mid_reset", 0);

      // Accumulator clamp at +2^31-1, observed by walking back down
      burst(8200, 0, 262143);
      check("acc_pos_sat_dac", 65535);
      burst(8192, 0, -262144);
      check("acc_pos_sat_unwind", -1);
      burst(8192, 0, -262144);
      check("acc_neg_sat_dac", -65536);
      burst(8192, 0, 262143);
      check("acc_neg_sat_unwind", -8192);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
